// File: rtl/mstage_lsu.sv
// mstage_lsu: memory-stage pipeline register and single-transaction load/store unit.
// Ports: s_valid/s_ready + *X inputs from execute; mem_req_*/mem_resp_* data bus;
// m_valid/m_ready + *M outputs and faultM toward writeback. TIMEOUT=0 disables the
// response timeout.
module mstage_lsu #(
  parameter int TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic        mvalidX,
  input  logic        mwenX,
  input  logic [7:0]  mwmaskX,
  input  logic [2:0]  mrtypeX,
  input  logic [31:0] aluX,
  input  logic [31:0] src2X,
  input  logic [31:0] snpcX,
  input  logic [31:0] csrX,
  input  logic [2:0]  rdregsrcX,
  input  logic [4:0]  rdX,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  output logic        mem_wen,
  output logic [31:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_rdata,
  input  logic        mem_resp_err,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] aluM,
  output logic [31:0] rdataM,
  output logic [31:0] snpcM,
  output logic [31:0] csrM,
  output logic [2:0]  rdregsrcM,
  output logic [4:0]  rdM,
  output logic        faultM
);
  typedef enum logic [1:0] {IDLE, REQ, RESP, FULL} state_t;
  state_t r_state, w_next;
  logic [31:0] r_alu, r_rdata, r_snpc, r_csr, r_src2, r_cnt, w_ext;
  logic [7:0]  r_mask, w_byte;
  logic [15:0] w_half;
  logic [2:0]  r_rtype, r_rdsrc;
  logic [4:0]  r_rd;
  logic        r_wen, r_fault, w_accept, w_resp, w_timeout;
  assign s_ready   = (r_state == IDLE) || (r_state == FULL && m_ready);
  assign w_accept  = s_valid && s_ready;
  assign w_resp    = (r_state == RESP) && mem_resp_valid;
  assign w_timeout = (TIMEOUT != 0) && (r_state == RESP) && (r_cnt == 32'(TIMEOUT - 1));
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  always_comb begin
    w_next = w_accept ? (mvalidX ? REQ : FULL) :
             (r_state == FULL && m_ready)        ? IDLE :
             (r_state == REQ && mem_req_ready)   ? RESP :
             (w_resp || w_timeout)               ? FULL : r_state;
  end
  // byte lane from addr[1:0], halfword from addr[1]; misaligned halves are not trapped
  assign w_byte = 8'(mem_rdata >> {r_alu[1:0], 3'b000});
  assign w_half = r_alu[1] ? mem_rdata[31:16] : mem_rdata[15:0];
  assign w_ext  = (r_rtype == 3'd0) ? {{24{w_byte[7]}}, w_byte} :
                  (r_rtype == 3'd4) ? {24'b0, w_byte} :
                  (r_rtype == 3'd1) ? {{16{w_half[15]}}, w_half} :
                  (r_rtype == 3'd5) ? {16'b0, w_half} : mem_rdata;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_alu   <= '0;
      r_rdata <= '0;
      r_snpc  <= '0;
      r_csr   <= '0;
      r_src2  <= '0;
      r_cnt   <= '0;
      r_mask  <= '0;
      r_rtype <= '0;
      r_rdsrc <= '0;
      r_rd    <= '0;
      r_wen   <= 1'b0;
      r_fault <= 1'b0;
    end else begin
      if (w_accept) begin
        r_alu   <= aluX;
        r_snpc  <= snpcX;
        r_csr   <= csrX;
        r_src2  <= src2X;
        r_mask  <= mwmaskX;
        r_rtype <= mrtypeX;
        r_rdsrc <= rdregsrcX;
        r_rd    <= rdX;
        r_wen   <= mwenX;
        r_rdata <= '0;
        r_fault <= 1'b0;
      end
      if (r_state == REQ && mem_req_ready) r_cnt <= '0;
      else if (r_state == RESP)            r_cnt <= r_cnt + 32'd1;
      // a response arriving in the timeout cycle takes priority
      if (w_resp) begin
        r_rdata <= (mem_resp_err || r_wen) ? 32'd0 : w_ext;
        r_fault <= mem_resp_err;
      end else if (w_timeout) begin
        r_rdata <= '0;
        r_fault <= 1'b1;
      end
    end
  end
  assign mem_req_valid = (r_state == REQ);
  assign m_valid       = (r_state == FULL);
  assign mem_addr      = r_alu;
  assign mem_wen       = r_wen;
  assign mem_wdata     = r_src2;
  assign mem_wmask     = r_mask;
  assign aluM          = r_alu;
  assign rdataM        = r_rdata;
  assign snpcM         = r_snpc;
  assign csrM          = r_csr;
  assign rdregsrcM     = r_rdsrc;
  assign rdM           = r_rd;
  assign faultM        = r_fault;
endmodule

// File: tb/tb_mstage_lsu.sv
// tb_mstage_lsu: directed vectors and hand sequences for mstage_lsu.
module tb_mstage_lsu;
  logic        clk = 1'b0, rst;
  logic        s_valid, s_ready, mvalidX, mwenX;
  logic [7:0]  mwmaskX, mem_wmask;
  logic [2:0]  mrtypeX, rdregsrcX, rdregsrcM;
  logic [31:0] aluX, src2X, snpcX, csrX;
  logic [4:0]  rdX, rdM;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid, mem_resp_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        m_valid, m_ready, faultM;
  logic [31:0] aluM, rdataM, snpcM, csrM;
  int checks = 0, errors = 0;

  mstage_lsu #(.TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
    .mvalidX(mvalidX), .mwenX(mwenX), .mwmaskX(mwmaskX), .mrtypeX(mrtypeX),
    .aluX(aluX), .src2X(src2X), .snpcX(snpcX), .csrX(csrX),
    .rdregsrcX(rdregsrcX), .rdX(rdX),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata), .mem_resp_err(mem_resp_err),
    .m_valid(m_valid), .m_ready(m_ready),
    .aluM(aluM), .rdataM(rdataM), .snpcM(snpcM), .csrM(csrM),
    .rdregsrcM(rdregsrcM), .rdM(rdM), .faultM(faultM)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  rt;
    logic [31:0] rd;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] a, input logic [2:0] rt, input logic w,
                       input logic [7:0] mk, input logic [31:0] d);
    s_valid = 1'b1; mvalidX = 1'b1; aluX = a; mrtypeX = rt; mwenX = w; mwmaskX = mk; src2X = d;
    tick();
    s_valid = 1'b0; mvalidX = 1'b0; mwenX = 1'b0;
  endtask

  initial begin
    tbl[0] = '{32'h80000003, 3'd0, 32'h80FFFFFF, 32'hFFFFFF80};
    tbl[1] = '{32'h80000003, 3'd4, 32'h80FFFFFF, 32'h00000080};
    tbl[2] = '{32'h00000001, 3'd0, 32'h12345678, 32'h00000056};
    tbl[3] = '{32'h00000002, 3'd1, 32'h80011234, 32'hFFFF8001};
    tbl[4] = '{32'h00000002, 3'd5, 32'h80011234, 32'h00008001};
    tbl[5] = '{32'h00000000, 3'd1, 32'h80017FFF, 32'h00007FFF};
    tbl[6] = '{32'h00000000, 3'd2, 32'hCAFEBABE, 32'hCAFEBABE};
    tbl[7] = '{32'h00000003, 3'd3, 32'h11223344, 32'h11223344};
    tbl[8] = '{32'h00000001, 3'd1, 32'h0000F00F, 32'hFFFFF00F};
    rst = 1'b1; s_valid = 0; mvalidX = 0; mwenX = 0; mwmaskX = 0; mrtypeX = 0;
    aluX = 0; src2X = 0; snpcX = 0; csrX = 0; rdregsrcX = 0; rdX = 0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = 0; mem_resp_err = 0; m_ready = 0;
    #12;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_req_valid", mem_req_valid, 0);
    chk("rst_s_ready", s_ready, 1);
    chk("rst_aluM", aluM, 0);
    chk("rst_faultM", faultM, 0);
    rst = 1'b0;
    // non-memory back-to-back
    s_valid = 1; m_ready = 1; aluX = 1; snpcX = 32'h4; csrX = 32'hC5; rdX = 5'd7; rdregsrcX = 3'd3;
    tick();
    chk("b2b_alu1", aluM, 1); chk("b2b_mv1", m_valid, 1); chk("b2b_sr1", s_ready, 1);
    chk("b2b_snpc", snpcM, 32'h4); chk("b2b_csr", csrM, 32'hC5);
    chk("b2b_rd", rdM, 7); chk("b2b_rdsrc", rdregsrcM, 3);
    aluX = 2;
    tick();
    chk("b2b_alu2", aluM, 2); chk("b2b_mv2", m_valid, 1); chk("b2b_sr2", s_ready, 1);
    aluX = 3;
    tick();
    chk("b2b_alu3", aluM, 3); chk("b2b_mv3", m_valid, 1); chk("b2b_rdata", rdataM, 0);
    s_valid = 0;
    tick();
    chk("b2b_idle", m_valid, 0);
    // load extension table, immediate ready and response
    for (int i = 0; i < 9; i++) begin
      issue(tbl[i].addr, tbl[i].rt, 1'b0, 8'h00, 32'h0);
      chk($sformatf("ld%0d_req", i), mem_req_valid, 1);
      chk($sformatf("ld%0d_addr", i), mem_addr, tbl[i].addr);
      mem_req_ready = 1;
      tick();
      mem_req_ready = 0; mem_resp_valid = 1; mem_rdata = tbl[i].rd;
      tick();
      mem_resp_valid = 0;
      chk($sformatf("ld%0d_mv", i), m_valid, 1);
      chk($sformatf("ld%0d_rdata", i), rdataM, tbl[i].exp);
      chk($sformatf("ld%0d_fault", i), faultM, 0);
      tick();
    end
    // lb with request ready delayed two cycles, response one cycle later
    issue(32'h80000003, 3'd0, 1'b0, 8'h00, 32'h0);
    for (int i = 0; i < 3; i++) begin
      chk("dly_req", mem_req_valid, 1);
      chk("dly_addr", mem_addr, 32'h80000003);
      if (i == 2) mem_req_ready = 1;
      tick();
    end
    mem_req_ready = 0;
    chk("dly_req_drop", mem_req_valid, 0);
    tick();
    chk("dly_wait_mv", m_valid, 0);
    mem_resp_valid = 1; mem_rdata = 32'h80FFFFFF;
    tick();
    mem_resp_valid = 0;
    chk("dly_mv", m_valid, 1);
    chk("dly_rdata", rdataM, 32'hFFFFFF80);
    tick();
    // store with writeback stall
    m_ready = 0;
    issue(32'h100, 3'd2, 1'b1, 8'h0F, 32'hDEADBEEF);
    chk("st_wen", mem_wen, 1); chk("st_wdata", mem_wdata, 32'hDEADBEEF);
    chk("st_wmask", mem_wmask, 8'h0F); chk("st_addr", mem_addr, 32'h100);
    mem_req_ready = 1;
    tick();
    mem_req_ready = 0; mem_resp_valid = 1; mem_rdata = 32'h55555555;
    tick();
    mem_resp_valid = 0;
    chk("st_rdata", rdataM, 0);
    s_valid = 1; mvalidX = 0; aluX = 32'h999;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("st_hold_mv", m_valid, 1); chk("st_hold_sr", s_ready, 0);
      chk("st_hold_alu", aluM, 32'h100); chk("st_hold_req", mem_req_valid, 0);
      tick();
    end
    m_ready = 1;
    #1;
    chk("st_release_sr", s_ready, 1);
    tick();
    chk("st_next_alu", aluM, 32'h999); chk("st_next_mv", m_valid, 1);
    s_valid = 0;
    tick();
    // error response
    issue(32'h40, 3'd2, 1'b0, 8'h00, 32'h0);
    mem_req_ready = 1;
    tick();
    mem_req_ready = 0; mem_resp_valid = 1; mem_resp_err = 1; mem_rdata = 32'hFFFFFFFF;
    tick();
    mem_resp_valid = 0; mem_resp_err = 0;
    chk("err_fault", faultM, 1); chk("err_rdata", rdataM, 0); chk("err_mv", m_valid, 1);
    s_valid = 1; aluX = 32'h7;
    tick();
    s_valid = 0;
    chk("err_fault_clr", faultM, 0);
    tick();
    // timeout: FULL exactly 8 cycles after entering RESP
    issue(32'h44, 3'd2, 1'b0, 8'h00, 32'h0);
    mem_req_ready = 1;
    tick();
    mem_req_ready = 0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk($sformatf("to_mv%0d", i), m_valid, (i == 8) ? 1 : 0);
    end
    chk("to_fault", faultM, 1); chk("to_rdata", rdataM, 0);
    tick();
    // asynchronous reset during REQ drops mem_req_valid immediately
    issue(32'h48, 3'd2, 1'b0, 8'h00, 32'h0);
    #2; rst = 1; #1;
    chk("rst_req_drop", mem_req_valid, 0);
    chk("rst_req_alu", aluM, 0);
    rst = 0;
    tick();
    // asynchronous reset mid-RESP, then a stale response
    issue(32'h4C, 3'd2, 1'b0, 8'h00, 32'h0);
    mem_req_ready = 1;
    tick();
    mem_req_ready = 0;
    #2; rst = 1; #1;
    chk("rst_resp_mv", m_valid, 0); chk("rst_resp_req", mem_req_valid, 0);
    rst = 0;
    mem_resp_valid = 1; mem_rdata = 32'h12345678;
    tick();
    mem_resp_valid = 0;
    chk("stale_mv", m_valid, 0); chk("stale_sr", s_ready, 1); chk("stale_rdata", rdataM, 0);
    tick();
    chk("stale_mv2", m_valid, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mstage_lsu.md
Name: mstage_lsu

Overview:
- Memory-stage pipeline register and load/store unit; consumer end of the execute stage's s_valid/s_ready → m_valid/m_ready handshake.
- Accepts one instruction from execute and, for memory instructions, runs a single request/response transaction on the data bus.
- Sign/zero-extends load data and presents the result to writeback under the same valid/ready handshake.
- Replaces the pass-through behaviour once the core goes multi-cycle.

Parameters:
TIMEOUT, 256, cycles waited in RESP before an access fault is forced; 0 disables the timeout.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
s_valid  in  1  execute stage holds a valid instruction
s_ready  out  1  block can accept an instruction this cycle
mvalidX  in  1  instruction accesses memory
mwenX  in  1  access is a store
mwmaskX  in  8  store byte mask, forwarded unchanged
mrtypeX  in  3  load type: 0 lb, 1 lh, 2 lw, 4 lbu, 5 lhu
aluX  in  32  ALU result; used as the address for memory instructions
src2X  in  32  store data
snpcX  in  32  pc+4
csrX  in  32  CSR read value
rdregsrcX  in  3  writeback source select, forwarded
rdX  in  5  destination register
mem_req_valid  out  1  data-bus request
mem_req_ready  in  1  bus accepts the request
mem_addr  out  32  request address
mem_wen  out  1  request is a write
mem_wdata  out  32  write data
mem_wmask  out  8  write mask
mem_resp_valid  in  1  response present
mem_rdata  in  32  response data
mem_resp_err  in  1  response carries an error
m_valid  out  1  writeback-side data valid
m_ready  in  1  writeback stage accepts
aluM, rdataM, snpcM, csrM  out  32 each  registered results
rdregsrcM  out  3  registered
rdM  out  5  registered
faultM  out  1  access fault on this instruction

Behaviour:
- States: IDLE (empty), REQ (request outstanding), RESP (awaiting response), FULL (holding result).
- Reset value: state IDLE. Every output register is 0, including m_valid and mem_req_valid. Reset asserted mid-transaction abandons it; a response arriving after reset is ignored.
- s_ready is 1 in IDLE, 1 in FULL when m_ready=1, and 0 otherwise.
- Accept condition: s_valid && s_ready. On accept, capture every X input and clear faultM. Then:
  - mvalidX=0 → FULL next cycle, rdataM=0 (one-cycle latency).
  - mvalidX=1 → REQ next cycle.
- REQ:
  - mem_req_valid=1, with mem_addr=aluM, mem_wen, mem_wdata and mem_wmask from the captured values.
  - Request fields stay stable until mem_req_ready=1.
  - On mem_req_ready → RESP, drop mem_req_valid, clear the timeout counter.
- RESP:
  - The counter increments each cycle.
  - On mem_resp_valid → FULL.
    - Load: rdataM = extended data.
    - Store: rdataM = 0.
    - mem_resp_err=1: faultM=1, rdataM=0.
  - If TIMEOUT≠0 and the counter reaches TIMEOUT-1 without a response → FULL, faultM=1, rdataM=0.
  - A response and timeout in the same cycle: the response wins.
- Load extension, with byte lane selected by address bits [1:0]:
  - lb/lbu: selected byte, sign- or zero-extended.
  - lh/lhu: halfword selected by addr[1], sign- or zero-extended.
  - lw and any other code: full word.
  - No misalignment trap.
- FULL: m_valid=1.
  - m_ready=0: hold all outputs stable.
  - m_ready=1 and s_valid=1: accept the next instruction in the same cycle (back-to-back, no bubble). Go to FULL or REQ according to the new mvalidX.
  - m_ready=1 and s_valid=0: → IDLE, m_valid=0.
- m_valid is 0 in IDLE, REQ and RESP.
- mem_resp_valid in IDLE, REQ or FULL is ignored.
- Minimum latency from accept to m_valid: 1 cycle for non-memory, 3 cycles for memory (accept, REQ with immediate ready, RESP with immediate response).

Test Plan:
- Non-memory back-to-back: s_valid held high, m_ready=1, mvalidX=0, aluX=1,2,3 on consecutive cycles → aluM=1,2,3 on consecutive cycles, m_valid continuously 1, s_ready continuously 1.
- Load lb: aluX=0x80000003, mrtypeX=0, mem_rdata=0x80FFFFFF, mem_req_ready delayed 2 cycles, response 1 cycle later → mem_req_valid stable for 3 cycles; rdataM=0xFFFFFF80. Same test with mrtypeX=4 → rdataM=0x00000080.
- Store with stall: mwenX=1, mwmaskX=0x0F, src2X=0xDEADBEEF, m_ready=0 for 4 cycles after FULL → mem_wdata=0xDEADBEEF, mem_wmask=0x0F; outputs frozen; s_ready=0 until m_ready=1.
- Error and timeout: mem_resp_err=1 → faultM=1, rdataM=0. With TIMEOUT=8 and no response → FULL exactly 8 cycles after entering RESP, faultM=1.
- Reset mid-RESP: assert rst asynchronously between clock edges → m_valid and mem_req_valid go 0 immediately. A mem_resp_valid pulse after rst releases produces no m_valid.
